imdct_input_framer: RTL and testbench

- Sits directly downstream of antialias_reorder, between it and the IMDCT core.
- Accepts the serial, frequency-ordered ch1/ch2 sample stream (576 samples per channel per granule, 32 subbands x 18 lines).
- Groups the samples into 18-sample subband blocks in a two-bank ping-pong buffer.
- Replays each block to the IMDCT over a valid/ready handshake, tagged with subband index and effective block type.

---
 rtl/mp3_pkg.sv | 35 +++
 rtl/framer_bank_ram.sv | 28 ++
 rtl/imdct_input_framer.sv | 205 ++++++++++++++++++++
 tb/tb_imdct_input_framer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_pkg.sv
// Shared MP3 decoder constants and types: granule geometry, sample and block-type
// definitions, and the ping-pong buffer address helper used by imdct_input_framer.
package mp3_pkg;
   localparam int unsigned SAMPLE_W        = 32;
   localparam int unsigned LINES           = 18;
   localparam int unsigned SUBBANDS        = 32;
   localparam int unsigned GRANULE_SAMPLES = LINES * SUBBANDS;
   localparam int unsigned LINE_W          = 5;
   localparam int unsigned SB_W            = 5;
   localparam int unsigned ADDR_W          = 6;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      START  = 2'd1,
      SHORT  = 2'd2,
      STOP   = 2'd3
   } block_type_t;

   typedef struct packed {
      sample_t ch1;
      sample_t ch2;
   } pair_t;

   typedef enum logic {
      RD_IDLE   = 1'b0,
      RD_STREAM = 1'b1
   } rd_state_t;

   // Bank 0 occupies entries 0..17, bank 1 entries 18..35.
   function automatic logic [ADDR_W-1:0] ram_addr(input logic bank, input logic [LINE_W-1:0] line);
      return (bank ? ADDR_W'(LINES) : ADDR_W'(0)) + ADDR_W'(line);
   endfunction
endpackage

// File: rtl/framer_bank_ram.sv
// Two-bank x 18-entry sample-pair buffer: one write port, one registered read port
// whose output register doubles as the framer's ch1/ch2 output register.
module framer_bank_ram
   import mp3_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  pair_t             i_wdata,
   input  logic              i_re,
   input  logic [ADDR_W-1:0] i_raddr,
   output pair_t             o_rdata
);
   localparam int unsigned DEPTH = 2 * LINES;

   pair_t r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Read register holds its value while i_re is low so stalled beats stay stable.
   always_ff @(posedge clk) begin
      if (rst)       o_rdata <= '0;
      else if (i_re) o_rdata <= r_mem[i_raddr];
   end
endmodule

// File: rtl/imdct_input_framer.sv
// Groups the reordered ch1/ch2 stream into 18-line subband blocks in a ping-pong buffer
// and replays them to the IMDCT. Define FRAME_LEN_CHECK_EN to add the frame_err output.
module imdct_input_framer
   import mp3_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [SAMPLE_W-1:0] ch1_in,
   input  logic signed [SAMPLE_W-1:0] ch2_in,
   input  logic                       valid_in,
   input  logic                       new_frame_start,
   input  logic [1:0]                 block_type_in,
   input  logic                       mixed_block_flag_in,
   output logic signed [SAMPLE_W-1:0] ch1_out,
   output logic signed [SAMPLE_W-1:0] ch2_out,
   output logic [LINE_W-1:0]          line_out,
   output logic [SB_W-1:0]            subband_out,
   output logic [1:0]                 block_type_out,
   output logic                       block_start_out,
   output logic                       valid_out,
   input  logic                       ready_in,
`ifdef FRAME_LEN_CHECK_EN
   output logic                       frame_err,
`endif
   output logic                       overflow
);
   logic [LINE_W-1:0] r_wr_line;
   logic [SB_W-1:0]   r_wr_sb;
   logic              r_wr_bank;
   logic [1:0]        r_full;
   logic [SB_W-1:0]   r_tag_sb [2];
   block_type_t       r_tag_bt [2];
   block_type_t       r_btype;
   logic              r_mixed;
   logic              r_overflow;

   rd_state_t         r_state, w_state_nxt;
   logic              r_rd_bank, w_rd_bank_nxt;
   logic [LINE_W-1:0] r_rd_line, w_rd_line_nxt;
   logic              r_valid, w_valid_nxt;
   logic [SB_W-1:0]   r_sb_out;
   block_type_t       r_bt_out;
   logic              r_bs_out, w_bs_nxt;
   logic              w_load;

   logic [LINE_W-1:0] w_line_eff;
   logic [SB_W-1:0]   w_sb_eff;
   logic              w_hs, w_release, w_drop, w_wr, w_wr_last;
   block_type_t       w_bt_eff;
   logic [1:0]        w_set, w_clr;
   logic [ADDR_W-1:0] w_waddr, w_raddr;
   pair_t             w_wdata, w_rdata;

   // A frame start restarts the write position in the same cycle it arrives.
   assign w_line_eff = new_frame_start ? '0 : r_wr_line;
   assign w_sb_eff   = new_frame_start ? '0 : r_wr_sb;
   assign w_hs       = r_valid && ready_in;
   assign w_release  = w_hs && (r_rd_line == LINE_W'(LINES - 1));
   assign w_drop     = valid_in && (w_line_eff == '0) && r_full[r_wr_bank]
                       && !(w_release && (r_rd_bank == r_wr_bank));
   assign w_wr       = valid_in && !w_drop;
   assign w_wr_last  = w_wr && (w_line_eff == LINE_W'(LINES - 1));
   assign w_bt_eff   = (r_mixed && (w_sb_eff < SB_W'(2))) ? NORMAL : r_btype;
   assign w_set      = {w_wr_last & r_wr_bank, w_wr_last & ~r_wr_bank};
   assign w_clr      = {w_release & r_rd_bank, w_release & ~r_rd_bank};
   assign w_waddr    = ram_addr(r_wr_bank, w_line_eff);
   assign w_raddr    = ram_addr(w_rd_bank_nxt, w_rd_line_nxt);
   assign w_wdata    = {ch1_in, ch2_in};

   framer_bank_ram u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (w_load),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   // Write pointers, bank occupancy, per-bank tags and latched side info.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_line   <= '0;
         r_wr_sb     <= '0;
         r_wr_bank   <= 1'b0;
         r_full      <= '0;
         r_tag_sb[0] <= '0;
         r_tag_sb[1] <= '0;
         r_tag_bt[0] <= NORMAL;
         r_tag_bt[1] <= NORMAL;
         r_btype     <= NORMAL;
         r_mixed     <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (new_frame_start) begin
            r_btype <= block_type_t'(block_type_in);
            r_mixed <= mixed_block_flag_in;
         end
         if (w_wr_last) begin
            r_wr_line           <= '0;
            r_wr_sb             <= w_sb_eff + SB_W'(1);
            r_wr_bank           <= ~r_wr_bank;
            r_tag_sb[r_wr_bank] <= w_sb_eff;
            r_tag_bt[r_wr_bank] <= w_bt_eff;
         end else if (w_wr) begin
            r_wr_line <= w_line_eff + LINE_W'(1);
            r_wr_sb   <= w_sb_eff;
         end else if (new_frame_start) begin
            r_wr_line <= '0;
            r_wr_sb   <= '0;
         end
         r_full     <= (r_full & ~w_clr) | w_set;
         r_overflow <= w_drop | (r_overflow & ~new_frame_start);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= RD_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_rd_bank_nxt = r_rd_bank;
      w_rd_line_nxt = r_rd_line;
      w_load        = 1'b0;
      case (r_state)
         RD_IDLE: begin
            if (r_full[r_rd_bank]) begin
               w_state_nxt   = RD_STREAM;
               w_rd_line_nxt = '0;
               w_load        = 1'b1;
            end
         end
         RD_STREAM: begin
            if (w_release) begin
               w_rd_bank_nxt = ~r_rd_bank;
               w_rd_line_nxt = '0;
               // Back-to-back blocks stream without a bubble.
               if (r_full[~r_rd_bank]) w_load      = 1'b1;
               else                    w_state_nxt = RD_IDLE;
            end else if (w_hs) begin
               w_rd_line_nxt = r_rd_line + LINE_W'(1);
               w_load        = 1'b1;
            end
         end
         default: w_state_nxt = RD_IDLE;
      endcase
   end

   always_comb begin
      w_valid_nxt = (w_state_nxt == RD_STREAM);
      w_bs_nxt    = (w_rd_line_nxt == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_bank <= 1'b0;
         r_rd_line <= '0;
         r_valid   <= 1'b0;
         r_sb_out  <= '0;
         r_bt_out  <= NORMAL;
         r_bs_out  <= 1'b0;
      end else begin
         r_rd_bank <= w_rd_bank_nxt;
         r_rd_line <= w_rd_line_nxt;
         r_valid   <= w_valid_nxt;
         if (w_load) begin
            r_sb_out <= r_tag_sb[w_rd_bank_nxt];
            r_bt_out <= r_tag_bt[w_rd_bank_nxt];
            r_bs_out <= w_bs_nxt;
         end
      end
   end

`ifdef FRAME_LEN_CHECK_EN
   logic r_frame_err;
   logic r_wrote;

   // A granule that does not end on (0,0) after some accepted samples was mis-sized.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_err <= 1'b0;
         r_wrote     <= 1'b0;
      end else begin
         if (new_frame_start && r_wrote && ((r_wr_sb != '0) || (r_wr_line != '0)))
            r_frame_err <= 1'b1;
         if (new_frame_start) r_wrote <= w_wr;
         else if (w_wr)       r_wrote <= 1'b1;
      end
   end

   assign frame_err = r_frame_err;
`endif

   assign ch1_out         = w_rdata.ch1;
   assign ch2_out         = w_rdata.ch2;
   assign line_out        = r_rd_line;
   assign subband_out     = r_sb_out;
   assign block_type_out  = r_bt_out;
   assign block_start_out = r_bs_out;
   assign valid_out       = r_valid;
   assign overflow        = r_overflow;
endmodule

// File: tb/tb_imdct_input_framer.sv
// Self-checking bench for imdct_input_framer: a vector table for the basic block replay
// plus directed sequences for granule, stall, overflow, frame-start and reset cases.
`timescale 1ns/1ps
module tb_imdct_input_framer;
   import mp3_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ch1_in = '0, ch2_in = '0;
   logic        valid_in = 1'b0, new_frame_start = 1'b0, mixed_block_flag_in = 1'b0;
   logic [1:0]  block_type_in = '0;
   logic        ready_in = 1'b0;
   logic [31:0] ch1_out, ch2_out;
   logic [4:0]  line_out, subband_out;
   logic [1:0]  block_type_out;
   logic        block_start_out, valid_out, overflow;
`ifdef FRAME_LEN_CHECK_EN
   logic        frame_err;
`endif

   always #5 clk = ~clk;

   imdct_input_framer dut (
      .clk                 (clk),
      .rst                 (rst),
      .ch1_in              (ch1_in),
      .ch2_in              (ch2_in),
      .valid_in            (valid_in),
      .new_frame_start     (new_frame_start),
      .block_type_in       (block_type_in),
      .mixed_block_flag_in (mixed_block_flag_in),
      .ch1_out             (ch1_out),
      .ch2_out             (ch2_out),
      .line_out            (line_out),
      .subband_out         (subband_out),
      .block_type_out      (block_type_out),
      .block_start_out     (block_start_out),
      .valid_out           (valid_out),
      .ready_in            (ready_in),
`ifdef FRAME_LEN_CHECK_EN
      .frame_err           (frame_err),
`endif
      .overflow            (overflow)
   );

   typedef struct packed {
      logic [31:0] ch1;
      logic [31:0] ch2;
      logic [4:0]  line;
      logic [4:0]  sb;
      logic [1:0]  bt;
      logic        bs;
   } beat_t;

   typedef struct {
      logic [31:0] ch1_in;
      logic [31:0] ch2_in;
      logic [4:0]  exp_line;
      logic [4:0]  exp_sb;
      logic [1:0]  exp_bt;
      logic        exp_bs;
   } vec_t;

   beat_t      q[$];
   int         n_checks = 0;
   int         n_errors = 0;
   logic       p_valid = 1'b0, p_ready = 1'b0;
   logic [77:0] p_obs = '0;
   wire  [77:0] w_obs = {ch1_out, ch2_out, line_out, subband_out, block_type_out,
                         block_start_out, valid_out};

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Capture accepted beats and verify outputs hold across stalled cycles.
   always @(negedge clk) begin
      if (!rst && valid_out && ready_in)
         q.push_back({ch1_out, ch2_out, line_out, subband_out, block_type_out, block_start_out});
      if (!rst && p_valid && !p_ready)
         check("stall_hold", 128'(w_obs), 128'(p_obs));
      p_valid = valid_out && !rst;
      p_ready = ready_in;
      p_obs   = w_obs;
   end

   function automatic logic [31:0] pat(input int seed, input int sb, input int ln);
      return 32'((seed << 16) | (sb << 8) | ln);
   endfunction

   task automatic send(input logic [31:0] a, input logic [31:0] b);
      valid_in = 1'b1;
      ch1_in   = a;
      ch2_in   = b;
      @(posedge clk); #1;
      valid_in = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid_in = 1'b0;
      new_frame_start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      q.delete();
   endtask

   task automatic frame_start(input logic [1:0] bt, input logic mixed);
      new_frame_start     = 1'b1;
      block_type_in       = bt;
      mixed_block_flag_in = mixed;
      @(posedge clk); #1;
      new_frame_start = 1'b0;
   endtask

   // Wait (bounded) for n beats, let extra ones show up, then insist on exactly n.
   task automatic wait_beats(input string name, input int n, input int budget);
      int k = 0;
      while (q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      repeat (8) @(negedge clk);
      check(name, 128'(q.size()), 128'(n));
   endtask

   task automatic expect_beat(input string name, input logic [31:0] c1, input logic [31:0] c2,
                              input int line, input int sb, input int bt);
      beat_t exp, got;
      exp = {c1, c2, 5'(line), 5'(sb), 2'(bt), (line == 0)};
      got = '0;
      if (q.size() != 0) got = q.pop_front();
      check(name, 128'(got), 128'(exp));
   endtask

   initial begin
      vec_t tab [LINES];
      for (int i = 0; i < int'(LINES); i++) begin
         tab[i].ch1_in   = 32'(i);
         tab[i].ch2_in   = 32'(-i);
         tab[i].exp_line = 5'(i);
         tab[i].exp_sb   = 5'd0;
         tab[i].exp_bt   = 2'd0;
         tab[i].exp_bs   = (i == 0);
      end

      // Reset state
      do_reset();
      @(negedge clk);
      check("reset_outputs", 128'(w_obs), 128'(0));
      check("reset_overflow", 128'(overflow), 128'(0));
`ifdef FRAME_LEN_CHECK_EN
      check("reset_frame_err", 128'(frame_err), 128'(0));
`endif

      // Single block replay from the vector table
      @(posedge clk); #1;
      ready_in = 1'b1;
      for (int i = 0; i < int'(LINES); i++) send(tab[i].ch1_in, tab[i].ch2_in);
      @(negedge clk);
      check("valid_not_early", 128'(valid_out), 128'(0));
      @(negedge clk);
      check("valid_rise", 128'(valid_out), 128'(1));
      wait_beats("t1_count", int'(LINES), 60);
      for (int i = 0; i < int'(LINES); i++) begin
         beat_t got, exp;
         exp = {tab[i].ch1_in, tab[i].ch2_in, tab[i].exp_line, tab[i].exp_sb,
                tab[i].exp_bt, tab[i].exp_bs};
         got = '0;
         if (q.size() != 0) got = q.pop_front();
         check("t1_beat", 128'(got), 128'(exp));
      end

      // Full granule, short blocks with mixed flag
      do_reset();
      ready_in = 1'b1;
      frame_start(2'd2, 1'b1);
      for (int sb = 0; sb < int'(SUBBANDS); sb++)
         for (int ln = 0; ln < int'(LINES); ln++)
            send(pat(1, sb, ln), ~pat(1, sb, ln));
      wait_beats("t2_count", int'(GRANULE_SAMPLES), 200);
      for (int sb = 0; sb < int'(SUBBANDS); sb++)
         for (int ln = 0; ln < int'(LINES); ln++)
            expect_beat("t2_beat", pat(1, sb, ln), ~pat(1, sb, ln), ln, sb, (sb < 2) ? 0 : 2);
      check("t2_overflow", 128'(overflow), 128'(0));

      // Stall with both banks full: overflow and exactly two blocks afterwards
      do_reset();
      ready_in = 1'b0;
      for (int i = 0; i < 2 * int'(LINES); i++) send(pat(2, i / 18, i % 18), ~pat(2, i / 18, i % 18));
      for (int i = 0; i < int'(LINES); i++) send(32'hdead_0000 + 32'(i), 32'h0);
      @(negedge clk);
      check("t3_overflow", 128'(overflow), 128'(1));
      check("t3_stalled_valid", 128'({valid_out, line_out, subband_out}), 128'({1'b1, 5'd0, 5'd0}));
      repeat (5) @(negedge clk);
      @(posedge clk); #1;
      ready_in = 1'b1;
      wait_beats("t3_count", 2 * int'(LINES), 100);
      for (int i = 0; i < 2 * int'(LINES); i++)
         expect_beat("t3_beat", pat(2, i / 18, i % 18), ~pat(2, i / 18, i % 18), i % 18, i / 18, 0);

      // ready_in toggling every cycle
      do_reset();
      ready_in = 1'b1;
      fork
         for (int i = 0; i < 2 * int'(LINES); i++) send(pat(3, i / 18, i % 18), ~pat(3, i / 18, i % 18));
         repeat (120) begin
            @(posedge clk); #1;
            ready_in = ~ready_in;
         end
      join
      ready_in = 1'b1;
      wait_beats("t4_count", 2 * int'(LINES), 100);
      for (int i = 0; i < 2 * int'(LINES); i++)
         expect_beat("t4_beat", pat(3, i / 18, i % 18), ~pat(3, i / 18, i % 18), i % 18, i / 18, 0);
      check("t4_overflow", 128'(overflow), 128'(0));

      // Frame start after 25 samples, coincident with the first new sample
      do_reset();
      ready_in = 1'b1;
      frame_start(2'd0, 1'b0);
`ifdef FRAME_LEN_CHECK_EN
      check("t5_frame_err_clean", 128'(frame_err), 128'(0));
`endif
      for (int i = 0; i < 25; i++) send(pat(4, i / 18, i % 18), ~pat(4, i / 18, i % 18));
      new_frame_start = 1'b1;
      block_type_in = 2'd1;
      send(pat(5, 0, 0), ~pat(5, 0, 0));
      new_frame_start = 1'b0;
      for (int ln = 1; ln < int'(LINES); ln++) send(pat(5, 0, ln), ~pat(5, 0, ln));
`ifdef FRAME_LEN_CHECK_EN
      check("t5_frame_err", 128'(frame_err), 128'(1));
`endif
      wait_beats("t5_count", 2 * int'(LINES), 100);
      for (int ln = 0; ln < int'(LINES); ln++)
         expect_beat("t5_old_sb0", pat(4, 0, ln), ~pat(4, 0, ln), ln, 0, 0);
      for (int ln = 0; ln < int'(LINES); ln++)
         expect_beat("t5_new_sb0", pat(5, 0, ln), ~pat(5, 0, ln), ln, 0, 1);
      check("t5_overflow", 128'(overflow), 128'(0));

      // Reset in the middle of a stream
      do_reset();
      ready_in = 1'b1;
      for (int ln = 0; ln < int'(LINES); ln++) send(pat(6, 0, ln), ~pat(6, 0, ln));
      begin
         int k = 0;
         @(negedge clk);
         while (!(valid_out && line_out == 5'd9) && k < 60) begin
            @(negedge clk);
            k++;
         end
         check("t6_reached_line9", 128'(valid_out && line_out == 5'd9), 128'(1));
      end
      rst = 1'b1;
      @(negedge clk);
      check("t6_after_rst", 128'({w_obs, overflow}), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete();
      for (int ln = 0; ln < int'(LINES); ln++) send(pat(7, 0, ln), ~pat(7, 0, ln));
      wait_beats("t6_count", int'(LINES), 60);
      for (int ln = 0; ln < int'(LINES); ln++)
         expect_beat("t6_beat", pat(7, 0, ln), ~pat(7, 0, ln), ln, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
